// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared ALU op encodings and arbiter FSM states
//
// Purpose: constants shared by the arbiter top and the ALU it drives.
//   ALU_ADD..ALU_SRA : legal op encodings; anything above ALU_OP_MAX is illegal
//   state_t          : arbiter FSM states S_IDLE / S_EXEC / S_RESP
package alu_arbiter_pkg;

  localparam logic [2:0] ALU_ADD    = 3'd0;
  localparam logic [2:0] ALU_SUB    = 3'd1;
  localparam logic [2:0] ALU_AND    = 3'd2;
  localparam logic [2:0] ALU_OR     = 3'd3;
  localparam logic [2:0] ALU_SRL    = 3'd4;
  localparam logic [2:0] ALU_SRA    = 3'd5;
  localparam logic [2:0] ALU_OP_MAX = ALU_SRA;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// rtl/alu_arbiter_alu.sv - combinational 32-bit ALU shared by the arbiter
//
// Purpose: purely combinational add/sub/and/or/srl/sra.
// Ports:
//   a  in  WIDTH  operand A
//   b  in  WIDTH  operand B / shift amount (full value is used)
//   op in  OPW    operation select; illegal encodings give c = 0
//   c  out WIDTH  result
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OPW-1:0]   op,
  output logic [WIDTH-1:0] c
);

  localparam int SW = $clog2(WIDTH);

  // Shift amounts of WIDTH or more saturate instead of wrapping the
  // low shift bits, so the whole B value matters.
  logic shift_big;
  assign shift_big = (b >= WIDTH'(WIDTH));

  always_comb begin
    c = '0;
    case (op)
      OPW'(ALU_ADD): c = a + b;
      OPW'(ALU_SUB): c = a - b;
      OPW'(ALU_AND): c = a & b;
      OPW'(ALU_OR):  c = a | b;
      OPW'(ALU_SRL): c = shift_big ? '0 : (a >> b[SW-1:0]);
      OPW'(ALU_SRA): c = shift_big ? {WIDTH{a[WIDTH-1]}}
                                   : $unsigned($signed(a) >>> b[SW-1:0]);
      default:       c = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one ALU between two requesters
//
// Purpose: accepts one op at a time from requester 0 or 1, executes it on
// latched operands and holds the result until the owner takes it.
// Ports:
//   clk, reset                   clock (rising edge), async active-low reset
//   reqN_valid/ready/a/b/op      request channel of requester N (N = 0, 1)
//   rspN_valid/ready/c/err       response channel of requester N
//   busy                         FSM not idle
//   last_grant                   requester granted most recently
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int OPW    = 3,
  parameter bit ERR_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_c,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_c,
  output logic             rsp1_err,
  output logic             busy,
  output logic             last_grant
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] op_a, op_b;
  logic [OPW-1:0]   op_code;
  logic             owner;
  logic             last_grant_q;
  logic [WIDTH-1:0] c0_q, c1_q;
  logic             err0_q, err1_q;

  logic             grant;
  logic             accept;
  logic [WIDTH-1:0] alu_c;
  logic             alu_err;

  // Requester 1 wins when it is alone or when requester 0 was served last.
  assign grant = req1_valid & (~req0_valid | ~last_grant_q);

  assign alu_err = ERR_EN & (op_code > OPW'(ALU_OP_MAX));

  alu_arbiter_alu #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) u_alu (
    .a  (op_a),
    .b  (op_b),
    .op (op_code),
    .c  (alu_c)
  );

  // Ready is combinational in IDLE; it is also gated by reset so that every
  // handshake output reads 0 while reset is held.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        if (reset && (req0_valid || req1_valid)) begin
          accept     = 1'b1;
          req0_ready = ~grant;
          req1_ready = grant;
          state_nxt  = S_EXEC;
        end
      end
      S_EXEC: state_nxt = S_RESP;
      S_RESP: begin
        if ((!owner && rsp0_ready) || (owner && rsp1_ready)) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      op_a         <= '0;
      op_b         <= '0;
      op_code      <= '0;
      owner        <= 1'b0;
      last_grant_q <= 1'b1;
      c0_q         <= '0;
      c1_q         <= '0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_a         <= grant ? req1_a  : req0_a;
        op_b         <= grant ? req1_b  : req0_b;
        op_code      <= grant ? req1_op : req0_op;
        owner        <= grant;
        last_grant_q <= grant;
      end
      // Per-requester result registers keep each side's last result stable
      // while the other requester is being served.
      if (state == S_EXEC) begin
        if (owner) begin
          c1_q   <= alu_c;
          err1_q <= alu_err;
        end else begin
          c0_q   <= alu_c;
          err0_q <= alu_err;
        end
      end
    end
  end

  assign rsp0_valid = (state == S_RESP) & ~owner;
  assign rsp1_valid = (state == S_RESP) & owner;
  assign rsp0_c     = c0_q;
  assign rsp1_c     = c1_q;
  assign rsp0_err   = err0_q;
  assign rsp1_err   = err1_q;
  assign busy       = (state != S_IDLE);
  assign last_grant = last_grant_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [1:0]  ne_req_ready, ne_rsp_valid, ne_rsp_err;
  logic [31:0] req_a [2];
  logic [31:0] req_b [2];
  logic [2:0]  req_op [2];
  logic [31:0] rsp_c [2];
  logic [31:0] ne_rsp_c [2];
  logic        busy, last_grant, ne_busy, ne_last_grant;

  int n_tests = 0;
  int n_fail  = 0;

  alu_arbiter #(.WIDTH(32), .OPW(3), .ERR_EN(1'b1)) u_dut (
    .clk(clk), .reset(reset),
    .req0_valid(req_valid[0]), .req0_ready(req_ready[0]),
    .req0_a(req_a[0]), .req0_b(req_b[0]), .req0_op(req_op[0]),
    .req1_valid(req_valid[1]), .req1_ready(req_ready[1]),
    .req1_a(req_a[1]), .req1_b(req_b[1]), .req1_op(req_op[1]),
    .rsp0_valid(rsp_valid[0]), .rsp0_ready(rsp_ready[0]),
    .rsp0_c(rsp_c[0]), .rsp0_err(rsp_err[0]),
    .rsp1_valid(rsp_valid[1]), .rsp1_ready(rsp_ready[1]),
    .rsp1_c(rsp_c[1]), .rsp1_err(rsp_err[1]),
    .busy(busy), .last_grant(last_grant)
  );

  alu_arbiter #(.WIDTH(32), .OPW(3), .ERR_EN(1'b0)) u_dut_noerr (
    .clk(clk), .reset(reset),
    .req0_valid(req_valid[0]), .req0_ready(ne_req_ready[0]),
    .req0_a(req_a[0]), .req0_b(req_b[0]), .req0_op(req_op[0]),
    .req1_valid(req_valid[1]), .req1_ready(ne_req_ready[1]),
    .req1_a(req_a[1]), .req1_b(req_b[1]), .req1_op(req_op[1]),
    .rsp0_valid(ne_rsp_valid[0]), .rsp0_ready(rsp_ready[0]),
    .rsp0_c(ne_rsp_c[0]), .rsp0_err(ne_rsp_err[0]),
    .rsp1_valid(ne_rsp_valid[1]), .rsp1_ready(rsp_ready[1]),
    .rsp1_c(ne_rsp_c[1]), .rsp1_err(ne_rsp_err[1]),
    .busy(ne_busy), .last_grant(ne_last_grant)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: results from the arithmetic definition of each op.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                input logic [2:0] op, output logic [31:0] c,
                                output logic err);
    logic [31:0] ones;
    ones = 32'hFFFF_FFFF;
    c = 32'h0;
    err = 1'b0;
    case (op)
      3'd0: c = a + b;
      3'd1: c = a - b;
      3'd2: c = a & b;
      3'd3: c = a | b;
      3'd4: c = (b >= 32) ? 32'h0 : (a >> b);
      3'd5: begin
        if (b >= 32) c = a[31] ? ones : 32'h0;
        else         c = (a >> b) | (a[31] ? ~(ones >> b) : 32'h0);
      end
      default: err = 1'b1;
    endcase
  endfunction

  // Protocol monitors: no ready outside IDLE, at most one response valid,
  // and the bench keeps request fields stable while waiting for ready.
  logic [1:0]  prev_wait;
  logic [34:0] prev_req [2];
  initial prev_wait = 2'b00;
  always @(negedge clk) begin
    if (reset) begin
      if (busy && (req_ready != 2'b00)) begin
        n_tests++; n_fail++;
        $display("FAIL ready_while_busy: got %b expected 00", req_ready);
      end
      if (&rsp_valid) begin
        n_tests++; n_fail++;
        $display("FAIL rsp_onehot: got %b expected at most one", rsp_valid);
      end
      for (int r = 0; r < 2; r++) begin
        if (prev_wait[r] && req_valid[r] && prev_req[r] !== {req_op[r], req_a[r]}) begin
          n_tests++; n_fail++;
          $display("FAIL req_stable%0d: got %h expected %h", r, {req_op[r], req_a[r]}, prev_req[r]);
        end
        prev_wait[r] = req_valid[r] & ~req_ready[r];
        prev_req[r]  = {req_op[r], req_a[r]};
      end
    end else begin
      prev_wait = 2'b00;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Issue one op from requester r; returns at the first cycle its response is
  // visible. grd counts cycles spent waiting for ready, lat cycles from
  // acceptance to visible response.
  task automatic run_op(input int r, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, output logic [31:0] c,
                        output logic err, output logic ne_err,
                        output int grd, output int lat);
    @(posedge clk);
    #1;
    req_valid[r] = 1'b1; req_a[r] = a; req_b[r] = b; req_op[r] = op;
    grd = 0;
    @(negedge clk);
    while (!req_ready[r] && grd < 20) begin
      @(negedge clk);
      grd++;
    end
    @(posedge clk);
    #1 req_valid[r] = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!rsp_valid[r] && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    c = rsp_c[r]; err = rsp_err[r]; ne_err = ne_rsp_err[r];
  endtask

  typedef struct {
    int          r;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] exp_c;
    logic        exp_err;
  } vec_t;

  vec_t vecs [13];

  initial begin
    logic [31:0] c, mc;
    logic        err, ne_err, merr;
    int          grd, lat, g;

    vecs[0]  = '{0, 32'h7FFF_FFFF, 32'd1,          ALU_ADD, 32'h8000_0000, 1'b0};
    vecs[1]  = '{1, 32'd5,         32'd7,          ALU_SUB, 32'hFFFF_FFFE, 1'b0};
    vecs[2]  = '{1, 32'h8000_0000, 32'd40,         ALU_SRA, 32'hFFFF_FFFF, 1'b0};
    vecs[3]  = '{1, 32'h8000_0000, 32'd40,         ALU_SRL, 32'h0,         1'b0};
    vecs[4]  = '{0, 32'hDEAD_BEEF, 32'h1234_5678,  3'b110,  32'h0,         1'b1};
    vecs[5]  = '{1, 32'hDEAD_BEEF, 32'h1234_5678,  3'b111,  32'h0,         1'b1};
    vecs[6]  = '{0, 32'hF0F0_F0F0, 32'hFF00_FF00,  ALU_AND, 32'hF000_F000, 1'b0};
    vecs[7]  = '{1, 32'hF0F0_F0F0, 32'h0F0F_0F0F,  ALU_OR,  32'hFFFF_FFFF, 1'b0};
    vecs[8]  = '{0, 32'h8000_0000, 32'd31,         ALU_SRA, 32'hFFFF_FFFF, 1'b0};
    vecs[9]  = '{0, 32'h8000_0000, 32'd31,         ALU_SRL, 32'h1,         1'b0};
    vecs[10] = '{1, 32'hFFFF_FFFF, 32'd1,          ALU_ADD, 32'h0,         1'b0};
    vecs[11] = '{0, 32'h1234_5678, 32'd4,          ALU_SRA, 32'h0123_4567, 1'b0};
    vecs[12] = '{0, 32'h8000_0000, 32'd32,         ALU_SRL, 32'h0,         1'b0};

    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int r = 0; r < 2; r++) begin
      req_a[r] = 32'h0; req_b[r] = 32'h0; req_op[r] = 3'd0;
    end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {30'b0, req_ready}, 32'h0);
    check("rst_rsp_valid", {30'b0, rsp_valid}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_last_grant", {31'b0, last_grant}, 32'h1);
    check("rst_c0", rsp_c[0], 32'h0);
    check("rst_c1", rsp_c[1], 32'h0);
    req_valid = 2'b00;
    @(posedge clk);
    #1 reset = 1'b1;

    // Directed vectors
    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].op, c, err, ne_err, grd, lat);
      check($sformatf("vec%0d_c", i), c, vecs[i].exp_c);
      check($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
      check($sformatf("vec%0d_err_noen", i), {31'b0, ne_err}, 32'h0);
      check($sformatf("vec%0d_ready_wait", i), grd, 32'd0);
      check($sformatf("vec%0d_latency", i), lat, 32'd1);
    end

    // Fairness: both requesters valid continuously after a fresh reset
    @(posedge clk);
    do_reset();
    @(posedge clk);
    #1;
    for (int r = 0; r < 2; r++) begin
      req_a[r] = 32'd5; req_b[r] = 32'd7; req_op[r] = ALU_SUB;
    end
    req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      g = 0;
      @(negedge clk);
      while (req_ready == 2'b00 && g < 10) begin
        @(negedge clk);
        g++;
      end
      check($sformatf("fair%0d_grant", k), {30'b0, req_ready}, (k % 2) ? 32'h2 : 32'h1);
      @(posedge clk);
      #1 check($sformatf("fair%0d_last_grant", k), {31'b0, last_grant}, k % 2);
      g = 0;
      @(negedge clk);
      while (rsp_valid == 2'b00 && g < 10) begin
        @(negedge clk);
        g++;
      end
      check($sformatf("fair%0d_rsp_owner", k), {30'b0, rsp_valid}, (k % 2) ? 32'h2 : 32'h1);
      check($sformatf("fair%0d_c", k), rsp_c[k % 2], 32'hFFFF_FFFE);
    end
    req_valid = 2'b00;

    // Response stall: rsp0_ready low for 10 cycles with req1 pending
    rsp_ready[0] = 1'b0;
    run_op(0, 32'd3, 32'd4, ALU_ADD, c, err, ne_err, grd, lat);
    req_a[1] = 32'd10; req_b[1] = 32'd20; req_op[1] = ALU_ADD; req_valid[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check($sformatf("stall%0d_valid", k), {31'b0, rsp_valid[0]}, 32'h1);
      check($sformatf("stall%0d_c", k), rsp_c[0], 32'd7);
      check($sformatf("stall%0d_busy", k), {31'b0, busy}, 32'h1);
      check($sformatf("stall%0d_ready1", k), {31'b0, req_ready[1]}, 32'h0);
      @(negedge clk);
    end
    rsp_ready[0] = 1'b1;
    g = 0;
    @(negedge clk);
    while (!req_ready[1] && g < 10) begin
      @(negedge clk);
      g++;
    end
    check("stall_release_grant", {31'b0, req_ready[1]}, 32'h1);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    g = 0;
    @(negedge clk);
    while (!rsp_valid[1] && g < 10) begin
      @(negedge clk);
      g++;
    end
    check("stall_req1_c", rsp_c[1], 32'd30);

    // Reset during EXEC
    @(posedge clk);
    #1;
    req_a[1] = 32'd1; req_b[1] = 32'd2; req_op[1] = ALU_ADD; req_valid[1] = 1'b1;
    @(negedge clk);
    check("mid_accept", {31'b0, req_ready[1]}, 32'h1);
    @(posedge clk);
    #2 reset = 1'b0;
    req_valid[1] = 1'b0;
    #1;
    check("mid_busy", {31'b0, busy}, 32'h0);
    check("mid_rsp_valid", {30'b0, rsp_valid}, 32'h0);
    check("mid_ready", {30'b0, req_ready}, 32'h0);
    check("mid_c0", rsp_c[0], 32'h0);
    check("mid_c1", rsp_c[1], 32'h0);
    check("mid_err", {30'b0, rsp_err}, 32'h0);
    check("mid_last_grant", {31'b0, last_grant}, 32'h1);
    #1 reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("mid_no_rsp%0d", k), {29'b0, busy, rsp_valid}, 32'h0);
    end
    @(posedge clk);
    #1;
    req_a[0] = 32'd9; req_b[0] = 32'd4; req_op[0] = ALU_SUB;
    req_a[1] = 32'd9; req_b[1] = 32'd4; req_op[1] = ALU_ADD;
    req_valid = 2'b11;
    @(negedge clk);
    check("post_reset_grant", {30'b0, req_ready}, 32'h1);
    @(posedge clk);
    #1 req_valid = 2'b00;
    g = 0;
    @(negedge clk);
    while (!rsp_valid[0] && g < 10) begin
      @(negedge clk);
      g++;
    end
    check("post_reset_c", rsp_c[0], 32'd5);

    // Randomized ops against the reference model
    for (int i = 0; i < 60; i++) begin
      int          r;
      logic [31:0] a, b;
      logic [2:0]  op;
      r  = $urandom_range(1, 0);
      a  = $urandom;
      b  = ($urandom_range(3, 0) == 0) ? $urandom : $urandom_range(40, 0);
      op = 3'($urandom_range(7, 0));
      model(a, b, op, mc, merr);
      repeat ($urandom_range(2, 0)) @(posedge clk);
      run_op(r, a, b, op, c, err, ne_err, grd, lat);
      check($sformatf("rnd%0d_c", i), c, mc);
      check($sformatf("rnd%0d_err", i), {31'b0, err}, {31'b0, merr});
      check($sformatf("rnd%0d_latency", i), lat, 32'd1);
    end

    @(posedge clk);
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
